dff_share_arbiter: RTL and testbench
====================================

Name: dff_share_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D flip-flop register with true and complement outputs (q/qb).
- NREQ requesters compete to load the register; one winner per arbitration cycle via req/gnt handshake.
- The block owns the register and reports q, qb, the last writer's index and a write counter.
- Sits between requester agents and downstream logic consuming q/qb.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, register data width.
- CNT_W, 16, write-counter width; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; clears all state the instant it goes low.
- req  input  NREQ  per-requester write request, level, held until granted.
- d  input  NREQ*WIDTH  requester data, slice i = d[i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, one-cycle pulse, registered.
- q  output  WIDTH  shared register value.
- qb  output  WIDTH  bitwise complement of q, always ~q.
- owner  output  $clog2(NREQ)  index of last granted requester.
- valid  output  1  high once any write has occurred since reset.
- busy  output  1  high while FSM is in GRANT.
- wr_count  output  CNT_W  number of completed writes.

Behaviour:
- Reset (rst=0, async): gnt=0, q=0, qb=all ones, owner=0, valid=0, busy=0, wr_count=0, rr_ptr=0, state=IDLE.
- FSM states: IDLE, GRANT.
- IDLE, req==0: stay in IDLE; outputs hold.
- IDLE, req!=0: the winner w is the first set req bit searching upward from rr_ptr, wrapping NREQ-1 to 0. At that edge:
  - gnt[w]=1, q<=d slice w, qb<=~that slice, owner<=w.
  - valid<=1, wr_count<=wr_count+1 (wraps), rr_ptr<=(w+1) mod NREQ.
  - state<=GRANT.
- GRANT: lasts exactly one cycle, busy=1, gnt visible. At the next edge gnt<=0 and state<=IDLE. No arbitration occurs in GRANT.
- Latency: req sampled high at edge k gives gnt high from edge k through edge k+1. Data is captured at the same edge gnt rises.
- Requester handshake: drop req at the edge after seeing gnt. A req still high in IDLE is a new request. Max throughput is one write per 2 cycles.
- Fairness: under continuous requests from all NREQ, each requester is granted once per 2*NREQ cycles.
- d of non-winners is ignored. d of the winner is sampled only at the grant edge; later changes do not affect q.
- Reset mid-GRANT: gnt drops immediately and the write counter does not advance again. The captured q is lost (q=0).
- rr_ptr is never out of range for non-power-of-two NREQ.

Optional Feature:
- Macro DFF_SHARE_LOCK_EN.
- Defined:
  - Adds input lock [NREQ].
  - If in GRANT the owner has req[owner]=1 and lock[owner]=1, the FSM stays in GRANT.
  - Each cycle it re-captures d[owner] and increments wr_count, with gnt[owner] held high (burst writes, one per cycle).
  - rr_ptr is not advanced during the burst.
  - Dropping lock or req ends the burst: gnt<=0, IDLE at the next edge.
- Not defined: no lock port; GRANT is always exactly one cycle.

Test Plan:
- Reset values: rst low for 3 cycles, then high, no req -> q=8'h00, qb=8'hFF, gnt=0, valid=0, wr_count=0. Assert rst low mid-GRANT -> gnt=0 and q=0 immediately, without waiting for clk.
- Single request: req=4'b0100, d[2]=8'hA5 -> gnt=4'b0100 one cycle, q=8'hA5, qb=8'h5A, owner=2, wr_count=1, next cycle gnt=0, busy=0.
- Round-robin: req=4'b1111 held continuously, d[i]=8'h10+i -> grants 0,1,2,3,0 on cycles 1,3,5,7,9; q follows 8'h10,11,12,13,10; wr_count=5.
- Pointer wrap and skip: after a grant to 3, req=4'b0101 -> grant 0 first, then 2.
- Data stability: change d[1] from 8'h33 to 8'hCC one cycle after gnt[1] -> q remains 8'h33.
- Counter wrap with CNT_W=4: 17 writes -> wr_count=1. Lock build: req[1]=lock[1]=1 for 4 cycles, d[1]=0,1,2,3 -> gnt[1] high 4 cycles, q=3, wr_count+=4.

Source files
------------

// File: rtl/dff_share_arbiter.sv
// ---------------------------------------------------------------------------
// dff_share_arbiter
//
// Round-robin arbiter and write sequencer that owns one shared WIDTH-bit
// register with true (q) and complement (qb) outputs.  NREQ requesters
// compete to load it; exactly one winner per arbitration cycle receives a
// registered, one-hot, one-cycle gnt pulse.  The winner's data is captured
// on the same edge that gnt rises.
//
// Optional build macro: DFF_SHARE_LOCK_EN
//   When defined, a lock input is added.  A granted owner that keeps both
//   req and lock high stays in GRANT and writes every cycle (burst mode).
//   When undefined, GRANT always lasts exactly one cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   req       in   [NREQ]        level requests, held until granted
//   d         in   [NREQ*WIDTH]  requester data, slice i = d[i*WIDTH +: WIDTH]
//   lock      in   [NREQ]        burst lock (DFF_SHARE_LOCK_EN only)
//   gnt       out  [NREQ]        registered one-hot grant
//   q         out  [WIDTH]       shared register
//   qb        out  [WIDTH]       always ~q
//   owner     out  [log2 NREQ]   index of last granted requester
//   valid     out  1             a write has occurred since reset
//   busy      out  1             FSM is in GRANT
//   wr_count  out  [CNT_W]       completed writes, wraps
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting; arbitrates among req from rr_ptr upward each cycle
// GRANT  | gnt asserted for the winner; no arbitration (burst hold if locked)
// ---------------------------------------------------------------------------
module dff_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int OW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] d,
`ifdef DFF_SHARE_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      qb,
    output logic [OW-1:0]         owner,
    output logic                  valid,
    output logic                  busy,
    output logic [CNT_W-1:0]      wr_count
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [OW-1:0]    rr_ptr;
    logic [OW-1:0]    ptr_d;
    logic [NREQ-1:0]  gnt_d;
    logic [WIDTH-1:0] q_d;
    logic [OW-1:0]    owner_d;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_d;

    logic [OW-1:0]    win;
    logic             win_found;
    logic [OW-1:0]    ptr_next;
    logic [WIDTH-1:0] win_data;
    logic [OW:0]      scan_sum;
    logic [OW-1:0]    scan_idx;

    // Search upward from rr_ptr with wrap.  The sum is one bit wider than the
    // pointer and reduced by NREQ explicitly so non-power-of-two NREQ never
    // produces an index past NREQ-1.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (OW+1)'(k);
            if (scan_sum >= (OW+1)'(NREQ)) begin
                scan_sum = scan_sum - (OW+1)'(NREQ);
            end
            scan_idx = scan_sum[OW-1:0];
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win       = scan_idx;
            end
        end
    end

    assign ptr_next = (win == OW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign win_data = d[win*WIDTH +: WIDTH];

`ifdef DFF_SHARE_LOCK_EN
    logic [WIDTH-1:0] own_data;
    logic             burst_hold;

    assign own_data   = d[owner*WIDTH +: WIDTH];
    assign burst_hold = req[owner] && lock[owner];
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        q_d     = q;
        owner_d = owner;
        valid_d = valid;
        cnt_d   = wr_count;
        ptr_d   = rr_ptr;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    state_d    = S_GRANT;
                    gnt_d[win] = 1'b1;
                    q_d        = win_data;
                    owner_d    = win;
                    valid_d    = 1'b1;
                    cnt_d      = wr_count + 1'b1;
                    ptr_d      = ptr_next;
                end
            end
            S_GRANT: begin
`ifdef DFF_SHARE_LOCK_EN
                // Burst: gnt stays as registered, pointer is left alone so the
                // rotation resumes after the locked owner once it lets go.
                if (burst_hold) begin
                    q_d   = own_data;
                    cnt_d = wr_count + 1'b1;
                end else begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
`else
                gnt_d   = '0;
                state_d = S_IDLE;
`endif
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            gnt      <= '0;
            q        <= '0;
            owner    <= '0;
            valid    <= 1'b0;
            wr_count <= '0;
            rr_ptr   <= '0;
        end else begin
            state_q  <= state_d;
            gnt      <= gnt_d;
            q        <= q_d;
            owner    <= owner_d;
            valid    <= valid_d;
            wr_count <= cnt_d;
            rr_ptr   <= ptr_d;
        end
    end

    assign qb   = ~q;
    assign busy = (state_q == S_GRANT);

endmodule

// File: tb/tb_dff_share_arbiter.sv
module tb_dff_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [WIDTH-1:0]      dv [NREQ];
    logic [NREQ*WIDTH-1:0] d;
`ifdef DFF_SHARE_LOCK_EN
    logic [NREQ-1:0]       lock = '0;
`endif
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qb;
    logic [1:0]            owner;
    logic                  valid;
    logic                  busy;
    logic [CNT_W-1:0]      wr_count;

    assign d = {dv[3], dv[2], dv[1], dv[0]};

    dff_share_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d       (d),
`ifdef DFF_SHARE_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .q       (q),
        .qb      (qb),
        .owner   (owner),
        .valid   (valid),
        .busy    (busy),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic push_grant(input logic [3:0] r);
        exp_t e;
        int   w;
        w = pick(r, m_ptr);
        e = '0;
        e.gnt[w] = 1'b1;
        e.q      = dv[w];
        e.owner  = 2'(w);
        m_cnt    = (m_cnt + 1) % 16;
        e.cnt    = 4'(m_cnt);
        m_ptr    = (w + 1) % NREQ;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every visible grant must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && gnt !== '0) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected_gnt got=%b expected none", gnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (gnt !== e.gnt) begin bad++; $display("FAIL sb_gnt got=%b exp=%b", gnt, e.gnt); end
                total++;
                if (q !== e.q) begin bad++; $display("FAIL sb_q got=%h exp=%h", q, e.q); end
                total++;
                if (qb !== ~e.q) begin bad++; $display("FAIL sb_qb got=%h exp=%h", qb, ~e.q); end
                total++;
                if (owner !== e.owner) begin bad++; $display("FAIL sb_owner got=%0d exp=%0d", owner, e.owner); end
                total++;
                if (wr_count !== e.cnt) begin bad++; $display("FAIL sb_wr_count got=%0d exp=%0d", wr_count, e.cnt); end
                total++;
                if (busy !== 1'b1 || valid !== 1'b1) begin
                    bad++; $display("FAIL sb_busy_valid got=%b%b exp=11", busy, valid);
                end
            end
        end
    end

    task automatic wait_grant(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (gnt !== '0) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_timeout got=no_gnt exp=gnt within 8 cycles", tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_ptr = 0;
        m_cnt = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
        total++;
        if (qb !== 8'hFF) begin bad++; $display("FAIL reset_qb got=%h exp=ff", qb); end
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy got=%b%b exp=00", valid, busy); end
        total++;
        if (wr_count !== 4'd0 || owner !== 2'd0) begin
            bad++; $display("FAIL reset_cnt_owner got=%0d/%0d exp=0/0", wr_count, owner);
        end
    endtask

    task automatic test_single();
        dv[2] = 8'hA5;
        req   = 4'b0100;
        push_grant(req);
        wait_grant("single");
        req = '0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL single_release got=%b/%b exp=0000/0", gnt, busy);
        end
        total++;
        if (q !== 8'hA5 || qb !== 8'h5A || owner !== 2'd2) begin
            bad++; $display("FAIL single_hold got=%h/%h/%0d exp=a5/5a/2", q, qb, owner);
        end
    endtask

    task automatic test_round_robin();
        int grants;
        do_reset();
        for (int i = 0; i < NREQ; i++) dv[i] = 8'h10 + 8'(i);
        req = 4'b1111;
        repeat (5) push_grant(req);
        grants = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                total++;
                if (gnt === '0) begin bad++; $display("FAIL rr_cycle%0d got=%b exp=grant", c, gnt); end
                else grants++;
            end else begin
                total++;
                if (gnt !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got=%b exp=0000", c, gnt); end
            end
            if (c == 9) req = '0;
        end
        @(negedge clk);
        total++;
        if (wr_count !== 4'd5 || grants != 5) begin
            bad++; $display("FAIL rr_count got=%0d grants=%0d exp=5", wr_count, grants);
        end
        total++;
        if (q !== 8'h10) begin bad++; $display("FAIL rr_last_q got=%h exp=10", q); end
    endtask

    task automatic test_ptr_wrap();
        logic [1:0] exp_own [3];
        logic [3:0] pats [3];
        exp_own[0] = 2'd3; exp_own[1] = 2'd0; exp_own[2] = 2'd2;
        pats[0] = 4'b1000; pats[1] = 4'b0101; pats[2] = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            req = pats[i];
            push_grant(req);
            wait_grant("wrap");
            req = '0;
            total++;
            if (owner !== exp_own[i]) begin bad++; $display("FAIL wrap_owner%0d got=%0d exp=%0d", i, owner, exp_own[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_data_stable();
        dv[1] = 8'h33;
        req   = 4'b0010;
        push_grant(req);
        wait_grant("stable");
        req   = '0;
        dv[1] = 8'hCC;
        repeat (2) @(negedge clk);
        total++;
        if (q !== 8'h33 || qb !== 8'hCC) begin bad++; $display("FAIL stable_q got=%h/%h exp=33/cc", q, qb); end
    endtask

    task automatic test_reset_mid_grant();
        dv[0] = 8'h77;
        req   = 4'b0001;
        push_grant(req);
        @(posedge clk);
        #2;
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL midrst_pre got=%b exp=0001", gnt); end
        rst = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL midrst_gnt got=%b/%b exp=0000/0", gnt, busy); end
        total++;
        if (q !== 8'h00 || qb !== 8'hFF) begin bad++; $display("FAIL midrst_q got=%h/%h exp=00/ff", q, qb); end
        total++;
        if (wr_count !== 4'd0 || valid !== 1'b0) begin bad++; $display("FAIL midrst_cnt got=%0d/%b exp=0/0", wr_count, valid); end
        req = '0;
        sb.delete();
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (wr_count !== 4'd0 || gnt !== 4'b0000) begin
            bad++; $display("FAIL midrst_after got=%0d/%b exp=0/0000", wr_count, gnt);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            dv[0] = 8'(i);
            req   = 4'b0001;
            push_grant(req);
            wait_grant("wrapcnt");
            req = '0;
            @(negedge clk);
        end
        total++;
        if (wr_count !== 4'd1) begin bad++; $display("FAIL cnt_wrap got=%0d exp=1", wr_count); end
        total++;
        if (q !== 8'd16 || valid !== 1'b1) begin bad++; $display("FAIL cnt_wrap_q got=%h/%b exp=10/1", q, valid); end
    endtask

`ifdef DFF_SHARE_LOCK_EN
    task automatic test_lock_burst();
        int   start;
        exp_t e;
        start = m_cnt;
        dv[1] = 8'd0;
        req   = 4'b0010;
        lock  = 4'b0010;
        push_grant(req);
        for (int i = 1; i < 4; i++) begin
            e = '0;
            e.gnt   = 4'b0010;
            e.q     = 8'(i);
            e.owner = 2'd1;
            m_cnt   = (m_cnt + 1) % 16;
            e.cnt   = 4'(m_cnt);
            sb.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (gnt !== 4'b0010) begin bad++; $display("FAIL lock_gnt%0d got=%b exp=0010", i, gnt); end
            if (i < 3) dv[1] = 8'(i + 1);
        end
        req  = '0;
        lock = '0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000 || q !== 8'd3) begin bad++; $display("FAIL lock_end got=%b/%h exp=0000/03", gnt, q); end
        total++;
        if (wr_count !== 4'((start + 4) % 16)) begin
            bad++; $display("FAIL lock_cnt got=%0d exp=%0d", wr_count, (start + 4) % 16);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) dv[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_data_stable();
        test_reset_mid_grant();
        test_counter_wrap();
`ifdef DFF_SHARE_LOCK_EN
        test_lock_burst();
`endif
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
